// File: rtl/des_key_schedule_pkg.sv
// -----------------------------------------------------------------------------
// des_key_schedule_pkg
// Shared definitions for the DES key schedule controller:
//   - state_t        : controller state encoding (IDLE / ROUND)
//   - PC1_TBL        : permuted choice 1 (64-bit key -> 56-bit C||D), 1-based DES bit numbers
//   - PC2_TBL        : permuted choice 2 (56-bit C||D -> 48-bit round key), 1-based bit numbers
//   - ENC_SHIFT      : left-rotate amount applied when stepping from round r+1 to r+2
//   - DEC_SHIFT      : right-rotate amount applied when stepping backwards through the schedule
//   - pc1(), rot_left(), rot_right() : helpers used by the top level
// DES bit 1 is the MSB, so DES bit n of a W-bit vector lives at vector index W-n.
// -----------------------------------------------------------------------------
package des_key_schedule_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUND = 1'b1
    } state_t;

    localparam int DES_ROUNDS = 16;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Entry 0 is consumed at load time (encrypt pre-rotates by 1, decrypt starts
    // from the unrotated PC-1 value which already equals C16/D16).
    localparam logic [1:0] ENC_SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    localparam logic [1:0] DEC_SHIFT [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Parity bits (8,16,..,64 in 1-based numbering) never appear in PC1_TBL.
    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] cd;
        logic [5:0]  src;
        logic [5:0]  dst;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            src     = 6'(64 - PC1_TBL[i]);
            dst     = 6'(55 - i);
            cd[dst] = key[src];
        end
        return cd;
    endfunction

    function automatic logic [27:0] rot_left(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[26:0], v[27]};
            2'd2:    r = {v[25:0], v[27:26]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] v, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd1:    r = {v[0], v[27:1]};
            2'd2:    r = {v[1:0], v[27:2]};
            default: r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_key_schedule_pc2.sv
// -----------------------------------------------------------------------------
// des_key_schedule_pc2
// Combinational PC-2 compression permutation: C||D (56 bits) -> round key (48 bits).
// Ports:
//   cd         in  56  concatenated C (bits 55:28) and D (bits 27:0), MSB = DES bit 1
//   round_key  out 48  permuted round key, MSB = DES bit 1
// -----------------------------------------------------------------------------
module des_key_schedule_pc2
    import des_key_schedule_pkg::*;
(
    input  logic [55:0] cd,
    output logic [47:0] round_key
);

    always_comb begin
        logic [5:0] src;
        logic [5:0] dst;
        round_key = '0;
        for (int i = 0; i < 48; i++) begin
            src            = 6'(56 - PC2_TBL[i]);
            dst            = 6'(47 - i);
            round_key[dst] = cd[src];
        end
    end

endmodule

// File: rtl/des_key_schedule.sv
// -----------------------------------------------------------------------------
// des_key_schedule
// Controller and key generator for an iterative DES datapath. A start strobe
// captures the key and direction, then for 16 cycles the block presents one
// round key per cycle (K1..K16 encrypt, K16..K1 decrypt) while steering the
// datapath load enable and source select. done_strobe_dout marks the cycle in
// which the datapath ciphertext is valid.
// Ports:
//   clk               in   1  rising-edge clock
//   reset             in   1  synchronous active-high reset (aborts a run)
//   start_strobe_din  in   1  start request, accepted only when idle
//   decrypt_din       in   1  direction, sampled with an accepted start
//   key_din           in  64  DES key, MSB = DES bit 1, parity bits ignored
//   enable_dout       out  1  datapath L/R load enable
//   source_sel_dout   out  1  0 = initial permutation, 1 = round feedback
//   round_key_dout    out 48  PC-2 of the current C/D registers
//   busy_dout         out  1  high while rounds are in progress (incl. done cycle)
//   done_strobe_dout  out  1  one-cycle pulse on the final round
// -----------------------------------------------------------------------------
module des_key_schedule
    import des_key_schedule_pkg::*;
#(
    parameter int ROUNDS = DES_ROUNDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_strobe_din,
    input  logic        decrypt_din,
    input  logic [63:0] key_din,
    output logic        enable_dout,
    output logic        source_sel_dout,
    output logic [47:0] round_key_dout,
    output logic        busy_dout,
    output logic        done_strobe_dout
);

    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t      state;
    logic [3:0]  round_cnt;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic        mode;

    logic        last_round;
    logic        start_ok;
    logic [55:0] key_pc1;
    logic [3:0]  sched_idx;
    logic [1:0]  enc_n;
    logic [1:0]  dec_n;

    assign last_round = (round_cnt == LAST_ROUND);
    assign start_ok   = (state == IDLE) && start_strobe_din;
    assign key_pc1    = pc1(key_din);
    // Stepping out of round r uses schedule entry r+1; never evaluated past r=14.
    assign sched_idx  = round_cnt + 4'd1;
    assign enc_n      = ENC_SHIFT[sched_idx];
    assign dec_n      = DEC_SHIFT[sched_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round_cnt <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            mode      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mode      <= decrypt_din;
                        round_cnt <= '0;
                        state     <= ROUND;
                        // Decrypt starts from C0/D0, which equal C16/D16
                        // because the full schedule rotates by 28.
                        if (decrypt_din) begin
                            c_reg <= key_pc1[55:28];
                            d_reg <= key_pc1[27:0];
                        end else begin
                            c_reg <= rot_left(key_pc1[55:28], 2'd1);
                            d_reg <= rot_left(key_pc1[27:0], 2'd1);
                        end
                    end
                end
                ROUND: begin
                    if (last_round) begin
                        // C/D deliberately held so the final key stays on the bus.
                        state <= IDLE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                        if (mode) begin
                            c_reg <= rot_right(c_reg, dec_n);
                            d_reg <= rot_right(d_reg, dec_n);
                        end else begin
                            c_reg <= rot_left(c_reg, enc_n);
                            d_reg <= rot_left(d_reg, enc_n);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Control outputs are pure decodes of the registered state, except the
    // idle-state enable which must load L0/R0 in the same cycle as the start.
    always_comb begin
        busy_dout        = (state == ROUND);
        source_sel_dout  = (state == ROUND);
        done_strobe_dout = (state == ROUND) && last_round;
        if (reset)
            enable_dout = 1'b0;
        else if (state == IDLE)
            enable_dout = start_strobe_din;
        else
            enable_dout = !last_round;
    end

    des_key_schedule_pc2 u_pc2 (
        .cd        ({c_reg, d_reg}),
        .round_key (round_key_dout)
    );

endmodule
